// File: rtl/grad_descent_top.sv
// Fixed-point gradient-descent minimiser for f(x) = (x - X_TARGET)^2 + Y_OFFSET.
// Values are Q24.8 (x) and Q56.8 (cost). The controller uses a level start/done handshake.
module grad_descent_top #(
    parameter int unsigned NUM_ITERATIONS = 50,
    parameter logic [31:0] LEARNING_RATE  = 32'h0000001A,
    parameter logic [31:0] X_TARGET       = 32'h00000300,
    parameter logic [63:0] Y_OFFSET       = 64'h0000000000000200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_op,
    input  logic [31:0] x_init,
    output logic [31:0] x_at_min,
    output logic [63:0] y_min,
    output logic        done_op
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] iter_cnt;
    logic [31:0] iter_cnt_nx;
    logic [31:0] x_q;
    logic [31:0] x_nx;
    logic [31:0] x_at_min_nx;
    logic [63:0] y_min_nx;
    logic        done_nx;

    logic [32:0] diff;
    logic [33:0] grad;
    logic [65:0] lr_ext;
    logic [65:0] grad_ext;
    logic [65:0] prod;
    logic [65:0] step;
    logic [66:0] upd;
    logic [31:0] x_upd;
    logic [65:0] diff_ext;
    logic [65:0] sq_full;
    logic [65:0] sq_sh;
    logic [63:0] sq64;
    logic [64:0] sum65;
    logic [63:0] y_eval;
    logic        last_iter;

    // Distance from the target, shared by the update and the cost evaluation.
    assign diff = {x_q[31], x_q} - {X_TARGET[31], X_TARGET};
    assign grad = {diff, 1'b0};

    // Update step: floor((LR * 2d) / 256), then saturate x - step into 32 bits.
    assign lr_ext   = {{34{LEARNING_RATE[31]}}, LEARNING_RATE};
    assign grad_ext = {{32{grad[33]}}, grad};
    assign prod     = lr_ext * grad_ext;
    assign step     = $signed(prod) >>> 8;
    assign upd      = {{35{x_q[31]}}, x_q} - {step[65], step};

    // Saturate the update result to the signed 32-bit range.
    always_comb begin
        x_upd = upd[31:0];
        if (!upd[66] && (|upd[65:31])) begin
            x_upd = 32'h7FFF_FFFF;
        end else if (upd[66] && !(&upd[65:31])) begin
            x_upd = 32'h8000_0000;
        end
    end

    // Cost: floor(d^2 / 256) + Y_OFFSET, both stages saturating.
    assign diff_ext = {{33{diff[32]}}, diff};
    assign sq_full  = diff_ext * diff_ext;
    assign sq_sh    = $signed(sq_full) >>> 8;
    assign sq64     = (|sq_sh[65:63]) ? 64'h7FFF_FFFF_FFFF_FFFF : sq_sh[63:0];
    assign sum65    = {sq64[63], sq64} + {Y_OFFSET[63], Y_OFFSET};

    // Saturate the cost sum to the signed 64-bit range.
    always_comb begin
        y_eval = sum65[63:0];
        if (sum65[64] != sum65[63]) begin
            y_eval = sum65[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        end
    end

    assign last_iter = ((iter_cnt + 32'd1) == NUM_ITERATIONS);

    // State register; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; start_op is only looked at in IDLE and DONE.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start_op) begin
                    state_nx = (NUM_ITERATIONS == 0) ? EVAL : ITER;
                end
            end
            ITER: begin
                if (last_iter) begin
                    state_nx = EVAL;
                end
            end
            EVAL: state_nx = DONE;
            DONE: begin
                if (!start_op) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    // Next values of the datapath and output registers for each state.
    always_comb begin
        x_nx        = x_q;
        iter_cnt_nx = iter_cnt;
        x_at_min_nx = x_at_min;
        y_min_nx    = y_min;
        done_nx     = done_op;
        unique case (state)
            IDLE: begin
                if (start_op) begin
                    x_nx        = x_init;
                    iter_cnt_nx = 32'd0;
                end
            end
            ITER: begin
                x_nx        = x_upd;
                iter_cnt_nx = iter_cnt + 32'd1;
            end
            EVAL: begin
                x_at_min_nx = x_q;
                y_min_nx    = y_eval;
                done_nx     = 1'b1;
            end
            DONE: begin
                if (!start_op) begin
                    done_nx = 1'b0;
                end
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q      <= 32'd0;
            iter_cnt <= 32'd0;
            x_at_min <= 32'd0;
            y_min    <= 64'd0;
            done_op  <= 1'b0;
        end else begin
            x_q      <= x_nx;
            iter_cnt <= iter_cnt_nx;
            x_at_min <= x_at_min_nx;
            y_min    <= y_min_nx;
            done_op  <= done_nx;
        end
    end

endmodule

// File: tb/tb_grad_descent_top.sv
// Directed bench for grad_descent_top: three instances with 50, 1 and 0 iterations.
// A small longint reference model supplies results for the multi-step cases.
module tb_grad_descent_top;

    localparam longint LR = 26;
    localparam longint XT = 768;
    localparam longint YO = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_op [3];
    logic [31:0] x_init   [3];
    logic [31:0] x_at_min [3];
    logic [63:0] y_min    [3];
    logic        done_op  [3];

    int checks = 0;
    int errors = 0;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    grad_descent_top #(.NUM_ITERATIONS(50)) u_n50 (
        .clk(clk), .rst(rst), .start_op(start_op[0]), .x_init(x_init[0]),
        .x_at_min(x_at_min[0]), .y_min(y_min[0]), .done_op(done_op[0])
    );

    grad_descent_top #(.NUM_ITERATIONS(1)) u_n1 (
        .clk(clk), .rst(rst), .start_op(start_op[1]), .x_init(x_init[1]),
        .x_at_min(x_at_min[1]), .y_min(y_min[1]), .done_op(done_op[1])
    );

    grad_descent_top #(.NUM_ITERATIONS(0)) u_n0 (
        .clk(clk), .rst(rst), .start_op(start_op[2]), .x_init(x_init[2]),
        .x_at_min(x_at_min[2]), .y_min(y_min[2]), .done_op(done_op[2])
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] xi, input int n,
                                  output logic [31:0] xo,
                                  output logic [63:0] yo);
        longint x;
        longint d;
        longint st;
        longint sq;
        x = longint'($signed(xi));
        for (int i = 0; i < n; i++) begin
            d  = x - XT;
            st = (LR * 2 * d) >>> 8;
            x  = x - st;
            if (x > 64'sd2147483647)  x = 64'sd2147483647;
            if (x < -64'sd2147483648) x = -64'sd2147483648;
        end
        d  = x - XT;
        sq = (d * d) >>> 8;
        xo = x[31:0];
        yo = sq + YO;
    endfunction

    task automatic run(input int k, input logic [31:0] xi, output int lat);
        @(negedge clk);
        x_init[k]   = xi;
        start_op[k] = 1'b1;
        lat = -1;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (done_op[k] !== 1'b1 && lat < 300);
    endtask

    task automatic drop(input int k, input string tag);
        @(negedge clk);
        start_op[k] = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_drop"}, {63'd0, done_op[k]}, 64'd0);
    endtask

    task automatic run_model(input string tag, input logic [31:0] xi);
        int          lat;
        logic [31:0] ex;
        logic [63:0] ey;
        model(xi, 50, ex, ey);
        run(0, xi, lat);
        chk({tag, "_lat"}, 64'(lat), 64'd51);
        chk({tag, "_x"}, {32'd0, x_at_min[0]}, {32'd0, ex});
        chk({tag, "_y"}, y_min[0], ey);
        drop(0, tag);
    endtask

    initial begin
        int          lat;
        logic [31:0] hx;
        logic [63:0] hy;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_op[k] = 1'b0;
            x_init[k]   = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", {32'd0, x_at_min[0]}, 64'd0);
        chk("rst_y", y_min[0], 64'd0);
        chk("rst_done", {63'd0, done_op[0]}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // One step from 5.0.
        run(1, 32'h500, lat);
        chk("n1_lat", 64'(lat), 64'd2);
        chk("n1_x", {32'd0, x_at_min[1]}, 64'h498);
        chk("n1_y", y_min[1], 64'h48A);
        drop(1, "n1");

        // No steps: cost at x_init only.
        run(2, 32'h100, lat);
        chk("n0_lat", 64'(lat), 64'd1);
        chk("n0_x", {32'd0, x_at_min[2]}, 64'h100);
        chk("n0_y", y_min[2], 64'h600);
        drop(2, "n0");

        // Starting at the minimum stays there.
        for (int r = 0; r < 2; r++) begin
            run(0, 32'h300, lat);
            chk("min_lat", 64'(lat), 64'd51);
            chk("min_x", {32'd0, x_at_min[0]}, 64'h300);
            chk("min_y", y_min[0], 64'h200);
            drop(0, "min");
        end

        // Large negative start, then hold start_op high with a new x_init.
        model(32'hD000_0000, 50, hx, hy);
        run(0, 32'hD000_0000, lat);
        chk("neg_lat", 64'(lat), 64'd51);
        chk("neg_x", {32'd0, x_at_min[0]}, {32'd0, hx});
        chk("neg_y", y_min[0], hy);
        x_init[0] = 32'h400;
        repeat (60) @(posedge clk);
        #1;
        chk("hold_done", {63'd0, done_op[0]}, 64'd1);
        chk("hold_x", {32'd0, x_at_min[0]}, {32'd0, hx});
        chk("hold_y", y_min[0], hy);
        drop(0, "neg");
        chk("keep_x", {32'd0, x_at_min[0]}, {32'd0, hx});
        chk("keep_y", y_min[0], hy);

        // Consecutive runs with stepped x_init.
        for (int i = 0; i < 4; i++) begin
            run_model($sformatf("loop%0d", i), 32'h400 + 32'(i) * 32'h100);
        end

        // Reset in the middle of a run, then a clean run.
        @(negedge clk);
        x_init[0]   = 32'h500;
        start_op[0] = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst         = 1'b1;
        start_op[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_x", {32'd0, x_at_min[0]}, 64'd0);
        chk("mid_rst_y", y_min[0], 64'd0);
        chk("mid_rst_done", {63'd0, done_op[0]}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("post_rst_idle", {63'd0, done_op[0]}, 64'd0);
        run_model("after_rst", 32'h500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grad_descent_top.md
Name: grad_descent_top

Overview:
- Fixed-point gradient-descent minimiser for a 1-D quadratic cost f(x) = (x − X_TARGET)^2 + Y_OFFSET.
- All values are Q24.8 two's complement.
- On start, loads x_init, applies NUM_ITERATIONS update steps x ← x − LR·f'(x), then reports the final x and the cost there.
- Top-level compute block, driven by a controller or bench through a level start/done handshake.

Parameters:
- NUM_ITERATIONS, 50: number of update steps (0 allowed).
- LEARNING_RATE, 32'h0000001A: step size, Q24.8 (0x1A ≈ 0.1016).
- X_TARGET, 32'h00000300: minimiser location, Q24.8 (3.0).
- Y_OFFSET, 64'h0000000000000200: cost at minimum, Q56.8 (2.0).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start_op  in  1  level request; sampled in IDLE
- x_init  in  32 signed  initial x, Q24.8
- x_at_min  out  32 signed  final x, Q24.8
- y_min  out  64 signed  f(x_at_min), Q56.8
- done_op  out  1  result valid; held until start_op drops

Behaviour:
- Interface: one clock domain (clk); rst is synchronous and active-high.
- Reset (rst=1 at a rising edge): state=IDLE, iteration counter=0, internal x=0, x_at_min=0, y_min=0, done_op=0. Reset overrides every state and aborts any run in progress.
- FSM states: IDLE, ITER, EVAL, DONE. All outputs are registered.
- IDLE:
  - If start_op=1: x ← x_init, counter ← 0, next state ITER (or EVAL when NUM_ITERATIONS=0).
  - Otherwise stay in IDLE.
- ITER: one update per cycle.
  - d = x − X_TARGET (33-bit signed).
  - g = 2·d (34-bit).
  - step = (LEARNING_RATE · g) >>> 8, arithmetic shift, floor rounding, computed in a 66-bit product.
  - x ← sat32(x − step), saturating to 0x7FFFFFFF / 0x80000000.
  - counter++. After the NUM_ITERATIONS-th update, go to EVAL.
- EVAL:
  - d = x − X_TARGET (33-bit).
  - sq = (d·d) >>> 8, saturated to 64-bit signed max.
  - y_min ← sat64(sq + Y_OFFSET).
  - x_at_min ← x, done_op ← 1, next state DONE.
- DONE:
  - Hold x_at_min, y_min and done_op=1 while start_op=1.
  - When start_op=0: done_op ← 0, go to IDLE. Outputs keep their values until the next EVAL or reset.
- Latency: when start_op is sampled high in IDLE at edge 0, done_op is high after edge NUM_ITERATIONS+1.
- start_op changes during ITER/EVAL are ignored; a run always completes.
- Dropping and re-raising start_op between runs is required. A start_op held high after done does not retrigger until it has been seen low in DONE.
- x_init is sampled only at the IDLE→ITER/EVAL transition.
- Start in the same cycle as reset: reset wins.

Test Plan:
- Fixed point: NUM_ITERATIONS=1, x_init=0x500 (5.0) → step=0x68, x_at_min=0x498, y_min=0x48A (650+512), done_op high 2 edges after start.
- At the minimum: NUM_ITERATIONS=50, x_init=0x300 → x_at_min=0x300, y_min=0x200 every run.
- Large negative start: defaults, x_init=0xD0000000 → no overflow; x_at_min = bit-exact model result (≈ −37 + 3, well inside ±2^23); y_min matches the model; done_op rises at edge 51.
- Zero iterations: NUM_ITERATIONS=0, x_init=0x100 → x_at_min=0x100, y_min=0x600, done_op after 1 edge.
- Handshake:
  - Hold start_op high after done → done_op stays 1 and no rerun occurs.
  - Drop start_op → done_op=0 next edge.
  - Raise start_op with x_init=0x400 → new result; run loops of 4 consecutive cases with x_init incremented by 0x100.
- Reset mid-run: assert rst during ITER → all outputs 0 and state IDLE next edge; a subsequent start completes normally.
